// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, redirect/drain handling, registered decode word.
// Optional: define FETCH_CTRL_MISALIGN_TRAP_EN to trap misaligned redirects into a sticky ERR state.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] Instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        misalign_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    , S_ERR
`endif
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instrPc;
  logic        r_valid;
  logic        r_req;
  logic [31:0] w_redirTarget;

  // Low address bits are dropped; with the trap enabled they are already zero when used.
  assign w_redirTarget = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_misaligned;
  assign w_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign misalign_err = r_misalign;
`else
  assign misalign_err = 1'b0;
`endif

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign Instruction = r_instr;
  assign instr_pc    = r_instrPc;
  assign instr_valid = r_valid;

  // A redirect outranks everything; a response that was in flight when it hit is drained, never shown.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_instr   <= 32'h0;
      r_instrPc <= 32'h0;
      r_valid   <= 1'b0;
      r_req     <= 1'b0;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      r_req <= 1'b0;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
      if (r_state == S_ERR) begin
        r_state <= S_ERR;
      end else if (w_misaligned) begin
        r_misalign <= 1'b1;
        r_valid    <= 1'b0;
        r_state    <= S_ERR;
      end else
`endif
      if (redirect_valid) begin
        r_pc    <= w_redirTarget;
        r_valid <= 1'b0;
        if ((r_state == S_REQ) ||
            ((r_state == S_WAIT) && !imem_rvalid) ||
            ((r_state == S_DRAIN) && !imem_rvalid)) begin
          r_state <= S_DRAIN;
        end else begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end
          S_REQ: begin
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              r_instr   <= imem_rdata;
              r_instrPc <= r_pc;
              r_valid   <= 1'b1;
              r_pc      <= r_pc + 32'd4;
              r_state   <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (!stall) begin
              r_valid <= 1'b0;
              r_state <= S_REQ;
              r_req   <= 1'b1;
            end
          end
          S_DRAIN: begin
            if (imem_rvalid) begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic against a transaction-level fetch model.
`timescale 1ns/1ps
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  localparam bit trapEn = 1'b1;
`else
  localparam bit trapEn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] Instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        misalign_err;

  int nAssert = 0;
  int nFail = 0;
  int cycle = 0;

  // Memory responder state: one pending response, tagged stale if a reset overtook it.
  logic        memBusy = 1'b0;
  logic        memStale = 1'b0;
  logic        memStaleNow = 1'b0;
  int          memDue = 0;
  int          memLat = 1;
  logic [31:0] memData = 32'h0;

  // Transaction-level model of what the fetch unit should present.
  logic [31:0] mPc = RESET_PC;
  logic [31:0] mInstr = 32'h0;
  logic [31:0] mInstrPc = 32'h0;
  logic [31:0] mOutAddr = 32'h0;
  logic        mValid = 1'b0;
  logic        mReq = 1'b0;
  logic        mOut = 1'b0;
  logic        mKilled = 1'b0;
  logic        mErr = 1'b0;
  int          acceptCount = 0;

  logic [31:0] reqAddrQ[$];
  int          reqCycleQ[$];

  always #5 clock = ~clock;

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .Instruction    (Instruction),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .misalign_err   (misalign_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
    nAssert++;
    assert (obs === expVal) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expVal, cycle);
    end
  endtask

  // Deliver the pending response when due, then accept a new request seen this cycle.
  task automatic memStep();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    memStaleNow = 1'b0;
    if (memBusy) begin
      memDue--;
      if (memDue <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memData;
        memStaleNow = memStale;
        memBusy     = 1'b0;
      end
    end
    if (imem_req === 1'b1 && !reset) begin
      memBusy  = 1'b1;
      memDue   = memLat;
      memStale = 1'b0;
      memData  = $urandom;
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model, step the clock.
  task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic st);
    logic outNow;
    logic delivered;
    logic redirEff;
    logic accept;
    logic nextValid;
    memStep();
    redirect_valid = redir;
    redirect_pc    = rpc;
    stall          = st;
    if (imem_req === 1'b1) begin
      reqAddrQ.push_back(imem_addr);
      reqCycleQ.push_back(cycle);
    end
    checkOutput("imem_req", 32'(imem_req), 32'(mReq));
    if (mReq) checkOutput("imem_addr", imem_addr, mPc);
    checkOutput("instr_valid", 32'(instr_valid), 32'(mValid));
    if (mValid) begin
      checkOutput("Instruction", Instruction, mInstr);
      checkOutput("instr_pc", instr_pc, mInstrPc);
    end
    checkOutput("misalign_err", 32'(misalign_err), 32'(mErr));

    outNow = mOut || mReq;
    if (mReq) begin
      mOutAddr = mPc;
      mKilled  = 1'b0;
    end
    delivered = imem_rvalid && !memStaleNow;
    redirEff  = redir && !mErr;
    if (redirEff && trapEn && (rpc[1:0] != 2'b00)) begin
      mErr   = 1'b1;
      mValid = 1'b0;
      mReq   = 1'b0;
    end else if (!mErr) begin
      if (redirEff) mKilled = 1'b1;
      accept = delivered && outNow && !mKilled;
      if (redirEff) nextValid = 1'b0;
      else if (accept) nextValid = 1'b1;
      else if (mValid && !st) nextValid = 1'b0;
      else nextValid = mValid;
      if (accept) begin
        mInstr   = imem_rdata;
        mInstrPc = mOutAddr;
        acceptCount++;
      end
      if (redirEff) mPc = rpc & 32'hFFFF_FFFC;
      else if (accept) mPc = mPc + 32'd4;
      mValid = nextValid;
      mReq   = !(outNow && !delivered) && !nextValid;
    end
    mOut = outNow && !delivered;
    @(posedge clock);
    #1;
    cycle++;
  endtask

  // Asynchronous reset for two edges; any in-flight response becomes stale.
  task automatic applyReset();
    memStep();
    reset          = 1'b1;
    memStale       = 1'b1;
    redirect_valid = 1'b0;
    stall          = 1'b0;
    #1;
    checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
    checkOutput("rst_imem_addr", imem_addr, RESET_PC);
    checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_Instruction", Instruction, 32'd0);
    checkOutput("rst_instr_pc", instr_pc, 32'd0);
    checkOutput("rst_misalign_err", 32'(misalign_err), 32'd0);
    @(posedge clock);
    #1;
    cycle++;
    memStep();
    @(posedge clock);
    #1;
    cycle++;
    reset   = 1'b0;
    mPc     = RESET_PC;
    mValid  = 1'b0;
    mReq    = 1'b0;
    mOut    = 1'b0;
    mKilled = 1'b0;
    mErr    = 1'b0;
  endtask

  task automatic waitReq(input int bound);
    int n = 0;
    while (imem_req !== 1'b1 && n < bound) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      n++;
    end
    checkOutput("waitReq", 32'(imem_req), 32'd1);
  endtask

  task automatic waitValid(input int bound);
    int n = 0;
    while (instr_valid !== 1'b1 && n < bound) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      n++;
    end
    checkOutput("waitValid", 32'(instr_valid), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] savedInstr;
    logic [31:0] savedPc;
    int reqCount;
    int n;
    logic rRedir;
    logic [31:0] rPc;

    @(posedge clock);
    #1;

    // Startup stream at latency 1: requests to 0x0, 0x4, 0x8 three cycles apart.
    $display("[TB] startup stream");
    memLat = 1;
    applyReset();
    reqAddrQ.delete();
    reqCycleQ.delete();
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t1_nreq", 32'(reqAddrQ.size() >= 3), 32'd1);
    if (reqAddrQ.size() >= 3) begin
      checkOutput("t1_addr0", reqAddrQ[0], 32'h0);
      checkOutput("t1_addr1", reqAddrQ[1], 32'h4);
      checkOutput("t1_addr2", reqAddrQ[2], 32'h8);
      checkOutput("t1_gap01", 32'(reqCycleQ[1] - reqCycleQ[0]), 32'd3);
      checkOutput("t1_gap12", 32'(reqCycleQ[2] - reqCycleQ[1]), 32'd3);
    end

    // Decode stall holds the word and blocks fetch; fetch resumes the cycle after stall drops.
    $display("[TB] stall hold");
    waitValid(20);
    savedInstr = Instruction;
    savedPc    = instr_pc;
    for (int i = 0; i < 6; i++) begin
      checkOutput("t2_instr_stable", Instruction, savedInstr);
      checkOutput("t2_pc_stable", instr_pc, savedPc);
      checkOutput("t2_no_req", 32'(imem_req), 32'd0);
      applyStimulus(1'b0, 32'h0, (i < 5) ? 1'b1 : 1'b0);
    end
    checkOutput("t2_resume", 32'(imem_req), 32'd1);

    // Redirect during WAIT at latency 3: stale word drained, next fetch at 0x100.
    $display("[TB] redirect in WAIT");
    memLat = 3;
    waitReq(20);
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h100, 1'b0);
    n = 0;
    while (imem_req !== 1'b1 && n < 10) begin
      checkOutput("t3_no_valid", 32'(instr_valid), 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b0);
      n++;
    end
    checkOutput("t3_req", 32'(imem_req), 32'd1);
    checkOutput("t3_addr", imem_addr, 32'h100);

    // Redirect coinciding with the response: data dropped, fetch 0x200.
    $display("[TB] redirect with rvalid");
    memLat = 1;
    waitReq(20);
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h200, 1'b0);
    checkOutput("t4_valid", 32'(instr_valid), 32'd0);
    checkOutput("t4_req", 32'(imem_req), 32'd1);
    checkOutput("t4_addr", imem_addr, 32'h200);

    // Address wrap at the top of memory.
    $display("[TB] pc wrap");
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0);
    waitValid(20);
    checkOutput("t5_pc_top", instr_pc, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 32'h0, 1'b0);
    waitValid(20);
    checkOutput("t5_pc_wrap", instr_pc, 32'h0000_0000);

    // Reset while WAITing: late response lands in IDLE (latency 3) or REQ (latency 4).
    $display("[TB] reset mid-WAIT");
    for (int lat = 3; lat <= 4; lat++) begin
      memLat = lat;
      waitReq(20);
      applyStimulus(1'b0, 32'h0, 1'b0);
      applyReset();
      waitReq(5);
      checkOutput("t6_addr", imem_addr, RESET_PC);
      waitValid(20);
      checkOutput("t6_pc", instr_pc, RESET_PC);
    end

    // Misaligned redirect to 0x102.
    $display("[TB] misaligned redirect");
    memLat = 2;
    applyReset();
    waitValid(20);
    applyStimulus(1'b1, 32'h102, 1'b0);
    if (trapEn) begin
      checkOutput("t7_err", 32'(misalign_err), 32'd1);
      checkOutput("t7_valid", 32'(instr_valid), 32'd0);
      reqCount = 0;
      for (int i = 0; i < 10; i++) begin
        if (imem_req === 1'b1) reqCount++;
        applyStimulus((i == 3) ? 1'b1 : 1'b0, 32'h40, 1'b0);
      end
      checkOutput("t7_no_req", 32'(reqCount), 32'd0);
      checkOutput("t7_err_sticky", 32'(misalign_err), 32'd1);
      applyReset();
    end else begin
      checkOutput("t7_req", 32'(imem_req), 32'd1);
      checkOutput("t7_addr", imem_addr, 32'h100);
      checkOutput("t7_no_err", 32'(misalign_err), 32'd0);
    end

    // Random traffic: random latency, stalls and redirects against the model.
    $display("[TB] random traffic");
    applyReset();
    acceptCount = 0;
    for (int i = 0; i < 3000; i++) begin
      memLat = $urandom_range(1, 4);
      rRedir = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) rPc = 32'hFFFF_FFF8;
      else if (trapEn) rPc = $urandom & 32'hFFFF_FFFC;
      else rPc = $urandom;
      applyStimulus(rRedir, rPc, ($urandom_range(0, 2) == 0));
    end
    checkOutput("rand_progress", 32'(acceptCount > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-003 SHALL have port clock  in  1  rising-edge clock.
REQ-004 SHALL have port reset  in  1  asynchronous active-high reset.
REQ-005 SHALL have port imem_req  out  1  one-cycle fetch request.
REQ-006 SHALL have port imem_addr  out  32  fetch address, valid while imem_req=1.
REQ-007 SHALL have port imem_rvalid  in  1  response strobe, at least 1 cycle after the request.
REQ-008 SHALL have port imem_rdata  in  32  instruction word, valid with imem_rvalid.
REQ-009 SHALL have port redirect_valid  in  1  branch/jump redirect from execute.
REQ-010 SHALL have port redirect_pc  in  32  redirect target.
REQ-011 SHALL have port stall  in  1  decode cannot accept this cycle.
REQ-012 SHALL have port Instruction  out  32  registered instruction to decode.
REQ-013 SHALL have port instr_pc  out  32  address of Instruction.
REQ-014 SHALL have port instr_valid  out  1  Instruction holds an unconsumed word.
REQ-015 SHALL have port misalign_err  out  1  sticky misaligned-redirect flag.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, REQ, WAIT, HOLD, DRAIN and ERR; imem_req=1 only in REQ, with imem_addr=pc.
REQ-017 SHALL allow at most one outstanding request; REQ SHALL always go to WAIT on the next edge.
REQ-018 WAIT with imem_rvalid=1 SHALL latch Instruction=imem_rdata and instr_pc=pc, set instr_valid, set pc<=pc+4, and go to HOLD.
REQ-019 HOLD SHALL stay while stall=1; with stall=0 the word is consumed: clear instr_valid and go to REQ.
REQ-020 Throughput SHALL be one instruction per 3 cycles for 1-cycle memory latency and no stall.
REQ-021 pc+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-022 redirect_valid=1 in any state except ERR SHALL load pc<=redirect_pc and clear instr_valid on the next edge.
REQ-023 Redirect in REQ, or in WAIT without imem_rvalid, SHALL go to DRAIN.
REQ-024 Redirect in IDLE or HOLD, or in WAIT with imem_rvalid, SHALL go to REQ.
REQ-025 When redirect and imem_rvalid coincide, the redirect wins; the response data SHALL be discarded.
REQ-026 DRAIN SHALL discard the next imem_rvalid and then go to REQ.
REQ-027 A redirect in DRAIN SHALL update pc and remain in DRAIN, unless imem_rvalid is also 1, in which case it goes to REQ.
REQ-028 stall SHALL have no effect outside HOLD.

Reset
REQ-029 Reset SHALL force state=IDLE, pc=RESET_PC, Instruction=0, instr_pc=0, instr_valid=0 and misalign_err=0.
REQ-030 Reset SHALL force imem_req=0 and imem_addr=RESET_PC.
REQ-031 IDLE SHALL go to REQ on the first edge after reset deasserts.
REQ-032 Reset mid-WAIT SHALL abandon the outstanding request; a late imem_rvalid in IDLE or REQ SHALL be ignored.

Configuration
REQ-033 Macro FETCH_CTRL_MISALIGN_TRAP_EN defined: a redirect with redirect_pc[1:0]!=0 SHALL leave pc unchanged, set misalign_err, clear instr_valid and enter ERR.
REQ-034 In ERR, no requests SHALL issue and redirects SHALL be ignored; only reset clears ERR and misalign_err.
REQ-035 Macro undefined: redirect_pc[1:0] SHALL be treated as 2'b00, misalign_err SHALL be tied to 0, and ERR SHALL not exist.

Verification
REQ-036 Reset release, memory latency 1, stall=0 -> imem_addr sequence 0x0, 0x4, 0x8 with one imem_req every 3 cycles; Instruction/instr_pc track each response.
REQ-037 stall=1 for 5 cycles while instr_valid=1 -> Instruction and instr_pc stable and no imem_req; fetch resumes 1 cycle after stall falls.
REQ-038 Redirect to 0x100 during WAIT, latency 3 -> stale response dropped and never shown on Instruction; next imem_addr=0x100.
REQ-039 Redirect to 0x200 in the same cycle as imem_rvalid -> data dropped, instr_valid=0, next imem_addr=0x200.
REQ-040 Redirect to 0xFFFF_FFFC, then two fetches -> instr_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-041 With FETCH_CTRL_MISALIGN_TRAP_EN, redirect to 0x102 -> misalign_err=1, no further imem_req; reset clears. Without the macro, the same redirect fetches 0x100.
